// File: rtl/seq_gen_param_if.sv
// Control/status bundle for seq_gen_param.
// master: the block driving the generator; slave: the generator itself.
interface seq_gen_param_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             x_in;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             y_out;

  modport master (
    output en, x_in, mode, load, load_val,
    input  q, qn, y_out
  );

  modport slave (
    input  en, x_in, mode, load, load_val,
    output q, qn, y_out
  );
endinterface

// File: rtl/seq_gen_param.sv
// seq_gen_param: multi-mode WIDTH-bit sequence generator (binary, Gray,
// Johnson, optional Fibonacci LFSR) with load, direction and wrap flag.
// Optional feature macro: SEQ_GEN_LFSR_EN (mode 11 = LFSR; otherwise binary).
module seq_gen_param #(
  parameter int               WIDTH     = 3,
  parameter int               MAX_COUNT = (1 << WIDTH) - 1,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(3'b110)
) (
  input  logic           clk,
  input  logic           reset,
  seq_gen_param_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
  localparam logic [1:0]       M_GRAY = 2'b01;
  localparam logic [1:0]       M_JOHN = 2'b10;
  localparam logic [1:0]       M_LFSR = 2'b11;

`ifdef SEQ_GEN_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
  logic unused_taps;
  assign unused_taps = ^LFSR_TAPS;
`endif

  logic [WIDTH-1:0] st;
  logic [1:0]       mode_q;
  logic             y_q;

  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic [WIDTH-1:0] load_view;
  logic [WIDTH-1:0] origin;
  logic             mode_chg;
  logic [WIDTH-1:0] qn_val;

  function automatic logic [WIDTH-1:0] gray_map(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Binary/Gray presets saturate at the terminal value.
  function automatic logic [WIDTH-1:0] sat_max(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  function automatic logic is_lfsr(input logic [1:0] m);
    return LFSR_ON && (m == M_LFSR);
  endfunction

  function automatic logic [WIDTH-1:0] out_map(input logic [WIDTH-1:0] v,
                                               input logic [1:0] m);
    return (m == M_GRAY) ? gray_map(v) : v;
  endfunction

  // Next state and wrap detection for an enabled step in the latched mode.
  always_comb begin
    step_val  = st;
    step_wrap = 1'b0;
    case (mode_q)
      M_JOHN: begin
        if (bus.x_in) step_val = {st[WIDTH-2:0], ~st[WIDTH-1]};
        else          step_val = {~st[0], st[WIDTH-1:1]};
        step_wrap = (step_val == '0);
      end
`ifdef SEQ_GEN_LFSR_EN
      M_LFSR: begin
        // A zero state would lock up, so it is replaced by the origin.
        if (st == '0) step_val = ONE_V;
        else          step_val = {st[WIDTH-2:0], ^(st & LFSR_TAPS)};
        step_wrap = (step_val == ONE_V);
      end
`endif
      default: begin
        if (bus.x_in) begin
          step_val  = (st == MAX_V) ? '0 : st + ONE_V;
          step_wrap = (st == MAX_V);
        end else begin
          step_val  = (st == '0) ? MAX_V : st - ONE_V;
          step_wrap = (st == '0);
        end
      end
    endcase
  end

  // Preset value as it will be stored, plus origin of the requested mode.
  always_comb begin
    load_view = sat_max(bus.load_val);
    if (mode_q == M_JOHN) begin
      load_view = bus.load_val;
    end else if (is_lfsr(mode_q)) begin
      load_view = (bus.load_val == '0) ? ONE_V : bus.load_val;
    end
    origin   = is_lfsr(bus.mode) ? ONE_V : '0;
    mode_chg = (bus.mode != mode_q);
  end

  // Combinational preview of q after the coming edge.
  always_comb begin
    qn_val = out_map(st, mode_q);
    if (bus.load)      qn_val = out_map(load_view, mode_q);
    else if (mode_chg) qn_val = origin;
    else if (bus.en)   qn_val = out_map(step_val, mode_q);
  end

  // Core state: load > mode change > step > hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= '0;
      mode_q <= 2'b00;
      y_q    <= 1'b0;
    end else if (bus.load) begin
      st     <= load_view;
      y_q    <= 1'b0;
    end else if (mode_chg) begin
      mode_q <= bus.mode;
      st     <= origin;
      y_q    <= 1'b0;
    end else if (bus.en) begin
      st     <= step_val;
      y_q    <= step_wrap;
    end else begin
      y_q    <= 1'b0;
    end
  end

  assign bus.q     = out_map(st, mode_q);
  assign bus.qn    = qn_val;
  assign bus.y_out = y_q;

endmodule

// File: tb/tb_seq_gen_param.sv
// Directed bench for seq_gen_param: one instance with MAX_COUNT=7 and one
// with MAX_COUNT=5, both WIDTH=3, driven with identical stimulus.
module tb_seq_gen_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_gen_param_if #(.WIDTH(3)) bus7 ();
  seq_gen_param_if #(.WIDTH(3)) bus5 ();

  seq_gen_param #(.WIDTH(3), .MAX_COUNT(7), .LFSR_TAPS(3'b110)) dut7 (
    .clk(clk), .reset(reset), .bus(bus7.slave)
  );
  seq_gen_param #(.WIDTH(3), .MAX_COUNT(5), .LFSR_TAPS(3'b110)) dut5 (
    .clk(clk), .reset(reset), .bus(bus5.slave)
  );

  always #5 clk = ~clk;

  int exp_bin_q[9]  = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
  int exp_gray5[6]  = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b000};
  int exp_john[9]   = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000,
                        3'b001, 3'b011, 3'b111};
`ifdef SEQ_GEN_LFSR_EN
  int exp_m3_q[8]   = '{2, 5, 3, 7, 6, 4, 1, 2};
  int exp_m3_y[8]   = '{0, 0, 0, 0, 0, 0, 1, 0};
  int m3_origin     = 1;
`else
  int exp_m3_q[8]   = '{1, 2, 3, 4, 5, 6, 7, 0};
  int exp_m3_y[8]   = '{0, 0, 0, 0, 0, 0, 0, 1};
  int m3_origin     = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic x, input logic [1:0] m,
                       input logic l, input logic [2:0] lv);
    bus7.en = e; bus7.x_in = x; bus7.mode = m; bus7.load = l; bus7.load_val = lv;
    bus5.en = e; bus5.x_in = x; bus5.mode = m; bus5.load = l; bus5.load_val = lv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b1, 2'b00, 1'b0, 3'd0);
    #3;
    check("reset_q", 32'(bus7.q), 0);
    check("reset_y", 32'(bus7.y_out), 0);
    reset = 1'b1;
    step();
    check("idle_q", 32'(bus7.q), 0);

    // Binary up across the wrap.
    drive(1'b1, 1'b1, 2'b00, 1'b0, 3'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("bin_up_q[%0d]", i), 32'(bus7.q), exp_bin_q[i]);
      check($sformatf("bin_up_y[%0d]", i), 32'(bus7.y_out), (exp_bin_q[i] == 0) ? 1 : 0);
    end
    check("bin_qn", 32'(bus7.qn), 2);

    // Binary down through zero.
    drive(1'b1, 1'b0, 2'b00, 1'b0, 3'd0);
    step();
    check("bin_dn_q0", 32'(bus7.q), 0);
    check("bin_dn_y0", 32'(bus7.y_out), 0);
    step();
    check("bin_dn_q7", 32'(bus7.q), 7);
    check("bin_dn_y7", 32'(bus7.y_out), 1);

    // Asynchronous reset mid-count.
    drive(1'b0, 1'b1, 2'b00, 1'b1, 3'd5);
    step();
    check("load5_q", 32'(bus7.q), 5);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 3'd0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_q", 32'(bus7.q), 0);
    #1 reset = 1'b1;
    drive(1'b0, 1'b1, 2'b00, 1'b1, 3'd7);
    step();
    drive(1'b1, 1'b1, 2'b00, 1'b0, 3'd0);
    step();
    check("pre_rst_y", 32'(bus7.y_out), 1);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 3'd0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_y", 32'(bus7.y_out), 0);
    #1 reset = 1'b1;

    // Gray with MAX_COUNT=5.
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'd0);
    step();
    check("gray_origin", 32'(bus5.q), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("gray5_q[%0d]", i), 32'(bus5.q), exp_gray5[i]);
      check($sformatf("gray5_y[%0d]", i), 32'(bus5.y_out), (i == 5) ? 1 : 0);
    end
    drive(1'b1, 1'b1, 2'b01, 1'b1, 3'd7);
    #1;
    check("gray5_qn_load", 32'(bus5.qn), 3'b111);
    step();
    check("gray5_clamp", 32'(bus5.q), 3'b111);
    check("gray7_load7", 32'(bus7.q), 3'b100);

    // Johnson forward, then reverse at 111.
    drive(1'b1, 1'b1, 2'b10, 1'b0, 3'd0);
    step();
    check("john_origin", 32'(bus7.q), 0);
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("john_q[%0d]", i), 32'(bus7.q), exp_john[i]);
      check($sformatf("john_y[%0d]", i), 32'(bus7.y_out), (i == 5) ? 1 : 0);
    end
    drive(1'b1, 1'b0, 2'b10, 1'b0, 3'd0);
    #1;
    check("john_rev_qn", 32'(bus7.qn), 3'b011);
    step();
    check("john_rev_q", 32'(bus7.q), 3'b011);

    // Load beats a simultaneous mode change and step.
    drive(1'b1, 1'b1, 2'b00, 1'b1, 3'd5);
    step();
    check("prio_load_q", 32'(bus7.q), 3'b101);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 3'd0);
    #1;
    check("prio_qn_pend", 32'(bus7.qn), 0);
    step();
    check("prio_modechg_q", 32'(bus7.q), 0);
    step();
    check("prio_bin_q", 32'(bus7.q), 1);

    // Mode 11: LFSR or binary depending on the build.
    drive(1'b1, 1'b1, 2'b11, 1'b0, 3'd0);
    step();
    check("m3_origin", 32'(bus7.q), m3_origin);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("m3_q[%0d]", i), 32'(bus7.q), exp_m3_q[i]);
      check($sformatf("m3_y[%0d]", i), 32'(bus7.y_out), exp_m3_y[i]);
    end

    // Hold with en=0.
    drive(1'b0, 1'b1, 2'b11, 1'b0, 3'd0);
    step();
    check("hold_q", 32'(bus7.q), exp_m3_q[7]);
    check("hold_qn", 32'(bus7.qn), exp_m3_q[7]);
    check("hold_y", 32'(bus7.y_out), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
